reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 17 +
 rtl/reorder_buffer_if.sv | 56 +++++
 rtl/reorder_buffer.sv | 107 ++++++++++
 tb/tb_reorder_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout and sizing constants.
package reorder_buffer_pkg;

    localparam int ROB_SIZE  = 8;
    localparam int ROB_IDX_W = $clog2(ROB_SIZE);

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        has_rd;
        logic        is_branch;
        logic        mispredict;
        logic [4:0]  rd;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: allocation, CDB, operand lookup, commit and flush signals.
interface reorder_buffer_if import reorder_buffer_pkg::*; #(
    parameter int SIZE = ROB_SIZE
) ();
    localparam int IW = $clog2(SIZE);

    logic              alloc_valid_in;
    logic [4:0]        alloc_rd_in;
    logic              alloc_has_rd_in;
    logic              alloc_is_branch_in;
    logic              ready_out;
    logic [IW-1:0]     alloc_idx_out;

    logic              cdb_valid_in;
    logic [IW-1:0]     cdb_rob_idx_in;
    logic signed [31:0] cdb_data_in;
    logic              cdb_mispredict_in;

    logic [IW-1:0]     q1_idx_in;
    logic [IW-1:0]     q2_idx_in;
    logic              q1_ready_out;
    logic              q2_ready_out;
    logic [31:0]       q1_data_out;
    logic [31:0]       q2_data_out;

    logic              commit_valid_out;
    logic              commit_we_out;
    logic [4:0]        commit_rd_out;
    logic [31:0]       commit_data_out;
    logic [IW-1:0]     commit_idx_out;

    logic              flush_out;
    logic [4:0]        flush_addrs_out [SIZE];
    logic [IW:0]       count_out;

    modport master (
        output alloc_valid_in, alloc_rd_in, alloc_has_rd_in, alloc_is_branch_in,
        input  ready_out, alloc_idx_out,
        output cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in,
        output q1_idx_in, q2_idx_in,
        input  q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
        input  commit_valid_out, commit_we_out, commit_rd_out, commit_data_out, commit_idx_out,
        input  flush_out, flush_addrs_out, count_out
    );

    modport slave (
        input  alloc_valid_in, alloc_rd_in, alloc_has_rd_in, alloc_is_branch_in,
        output ready_out, alloc_idx_out,
        input  cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in,
        input  q1_idx_in, q2_idx_in,
        output q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
        output commit_valid_out, commit_we_out, commit_rd_out, commit_data_out, commit_idx_out,
        output flush_out, flush_addrs_out, count_out
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with mispredict flush.
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB results to operand lookups.
module reorder_buffer import reorder_buffer_pkg::*; #(
    parameter int SIZE = ROB_SIZE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    reorder_buffer_if.slave  bus
);
    localparam int IW = $clog2(SIZE);
    localparam int CW = IW + 1;

    rob_entry_t    ent [SIZE];
    logic [IW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          flush;
    logic [4:0]    faddr [SIZE];

    logic       commit_valid, mis_commit, do_alloc, ready;
    rob_entry_t hd;

    assign hd           = ent[head];
    assign commit_valid = hd.busy && hd.done;
    assign mis_commit   = commit_valid && hd.is_branch && hd.mispredict;
    // Full means full this cycle; a commit on the same edge does not open a slot.
    assign ready        = count < CW'(SIZE);
    assign do_alloc     = bus.alloc_valid_in && ready && !mis_commit;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < SIZE; i++) begin
                ent[i]   <= '0;
                faddr[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            flush <= 1'b0;
        end else begin
            flush <= mis_commit;
            if (mis_commit) begin
                // Capture tags still in flight, then drop everything.
                for (int i = 0; i < SIZE; i++) begin
                    faddr[i] <= (ent[i].busy && ent[i].has_rd) ? ent[i].rd : 5'd0;
                    ent[i]   <= '0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (bus.cdb_valid_in && ent[bus.cdb_rob_idx_in].busy) begin
                    ent[bus.cdb_rob_idx_in].done       <= 1'b1;
                    ent[bus.cdb_rob_idx_in].value      <= bus.cdb_data_in;
                    ent[bus.cdb_rob_idx_in].mispredict <= bus.cdb_mispredict_in;
                end
                if (commit_valid) begin
                    ent[head] <= '0;
                    head      <= head + IW'(1);
                end
                // Allocation is last so it wins over a CDB write to the same slot.
                if (do_alloc) begin
                    ent[tail] <= '{busy: 1'b1, done: 1'b0, has_rd: bus.alloc_has_rd_in,
                                   is_branch: bus.alloc_is_branch_in, mispredict: 1'b0,
                                   rd: bus.alloc_rd_in, value: 32'd0};
                    tail      <= tail + IW'(1);
                end
                case ({do_alloc, commit_valid})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.ready_out        = ready;
    assign bus.alloc_idx_out    = tail;
    assign bus.count_out        = count;
    assign bus.commit_valid_out = commit_valid;
    assign bus.commit_we_out    = commit_valid && hd.has_rd && (hd.rd != 5'd0);
    assign bus.commit_rd_out    = hd.rd;
    assign bus.commit_data_out  = hd.value;
    assign bus.commit_idx_out   = head;
    assign bus.flush_out        = flush;

    always_comb begin
        for (int i = 0; i < SIZE; i++) bus.flush_addrs_out[i] = faddr[i];
    end

    always_comb begin
        bus.q1_ready_out = ent[bus.q1_idx_in].busy && ent[bus.q1_idx_in].done;
        bus.q2_ready_out = ent[bus.q2_idx_in].busy && ent[bus.q2_idx_in].done;
        bus.q1_data_out  = bus.q1_ready_out ? ent[bus.q1_idx_in].value : 32'd0;
        bus.q2_data_out  = bus.q2_ready_out ? ent[bus.q2_idx_in].value : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (bus.cdb_valid_in && bus.cdb_rob_idx_in == bus.q1_idx_in && ent[bus.q1_idx_in].busy) begin
            bus.q1_ready_out = 1'b1;
            bus.q1_data_out  = bus.cdb_data_in;
        end
        if (bus.cdb_valid_in && bus.cdb_rob_idx_in == bus.q2_idx_in && ent[bus.q2_idx_in].busy) begin
            bus.q2_ready_out = 1'b1;
            bus.q2_data_out  = bus.cdb_data_in;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: alloc/commit, full/wrap, ordering, mispredict flush, reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   total = 0;
    int   bad   = 0;

`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reorder_buffer_if #(.SIZE(8)) bus ();
    reorder_buffer #(.SIZE(8)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid_in = 0; bus.alloc_rd_in = 0; bus.alloc_has_rd_in = 0;
        bus.alloc_is_branch_in = 0; bus.cdb_valid_in = 0; bus.cdb_rob_idx_in = 0;
        bus.cdb_data_in = 0; bus.cdb_mispredict_in = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        tick();
        tick();
        rst_in = 0;
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic has_rd, input logic br);
        bus.alloc_valid_in = 1; bus.alloc_rd_in = rd;
        bus.alloc_has_rd_in = has_rd; bus.alloc_is_branch_in = br;
        tick();
        bus.alloc_valid_in = 0;
    endtask

    task automatic cdb(input logic [2:0] idx, input int data, input logic mp);
        bus.cdb_valid_in = 1; bus.cdb_rob_idx_in = idx;
        bus.cdb_data_in = data; bus.cdb_mispredict_in = mp;
        tick();
        bus.cdb_valid_in = 0; bus.cdb_mispredict_in = 0;
        #1;
    endtask

    // Branch at idx0 followed by rd 4,5,6; mispredict posted so commit is pending.
    task automatic build_mispredict();
        do_reset();
        alloc(0, 0, 1); alloc(4, 1, 0); alloc(5, 1, 0); alloc(6, 1, 0);
        cdb(0, 1, 1);
    endtask

    initial begin
        idle();
        bus.q1_idx_in = 0; bus.q2_idx_in = 0;
        do_reset();
        chk("rst_ready", bus.ready_out, 1);
        chk("rst_alloc_idx", bus.alloc_idx_out, 0);
        chk("rst_count", bus.count_out, 0);
        chk("rst_commit_valid", bus.commit_valid_out, 0);
        chk("rst_flush", bus.flush_out, 0);
        chk("rst_q1_ready", bus.q1_ready_out, 0);

        // single alloc, CDB, commit
        alloc(5, 1, 0);
        #1;
        chk("a1_count", bus.count_out, 1);
        chk("a1_alloc_idx", bus.alloc_idx_out, 1);
        bus.cdb_valid_in = 1; bus.cdb_rob_idx_in = 0; bus.cdb_data_in = 42;
        #1;
        chk("a1_no_commit_yet", bus.commit_valid_out, 0);
        chk("a1_q1_bypass", bus.q1_ready_out, BYP);
        chk("a1_q1_bypass_data", bus.q1_data_out, BYP ? 42 : 0);
        tick();
        bus.cdb_valid_in = 0;
        #1;
        chk("a1_commit_valid", bus.commit_valid_out, 1);
        chk("a1_commit_we", bus.commit_we_out, 1);
        chk("a1_commit_rd", bus.commit_rd_out, 5);
        chk("a1_commit_data", bus.commit_data_out, 42);
        chk("a1_commit_idx", bus.commit_idx_out, 0);
        chk("a1_q1_ready", bus.q1_ready_out, 1);
        chk("a1_q1_data", bus.q1_data_out, 42);
        tick();
        chk("a1_count_after", bus.count_out, 0);
        chk("a1_commit_gone", bus.commit_valid_out, 0);

        // fill, overflow request, commit frees one slot
        do_reset();
        for (int i = 0; i < 8; i++) alloc(5'(i + 1), 1, 0);
        #1;
        chk("full_count", bus.count_out, 8);
        chk("full_ready", bus.ready_out, 0);
        chk("full_alloc_idx", bus.alloc_idx_out, 0);
        alloc(9, 1, 0);
        #1;
        chk("full_ignored_count", bus.count_out, 8);
        cdb(0, 100, 0);
        chk("full_commit_valid", bus.commit_valid_out, 1);
        chk("full_commit_rd", bus.commit_rd_out, 1);
        chk("full_commit_data", bus.commit_data_out, 100);
        chk("full_ready_same_cycle", bus.ready_out, 0);
        tick();
        chk("full_count_after", bus.count_out, 7);
        chk("full_ready_after", bus.ready_out, 1);
        chk("wrap_alloc_idx", bus.alloc_idx_out, 0);
        bus.q1_idx_in = 0;
        cdb(0, 7, 0);
        chk("cdb_nonbusy_q1", bus.q1_ready_out, 0);
        chk("cdb_nonbusy_q1_data", bus.q1_data_out, 0);
        chk("cdb_nonbusy_commit", bus.commit_valid_out, 0);

        // out-of-order completion, in-order commit
        do_reset();
        alloc(1, 1, 0); alloc(2, 1, 0);
        bus.q2_idx_in = 1;
        cdb(1, 11, 0);
        chk("ooo_wait", bus.commit_valid_out, 0);
        chk("ooo_q2_ready", bus.q2_ready_out, 1);
        chk("ooo_q2_data", bus.q2_data_out, 11);
        cdb(0, 10, 0);
        chk("ooo_c0_valid", bus.commit_valid_out, 1);
        chk("ooo_c0_idx", bus.commit_idx_out, 0);
        chk("ooo_c0_data", bus.commit_data_out, 10);
        tick();
        chk("ooo_c1_valid", bus.commit_valid_out, 1);
        chk("ooo_c1_idx", bus.commit_idx_out, 1);
        chk("ooo_c1_data", bus.commit_data_out, 11);
        tick();
        chk("ooo_empty", bus.count_out, 0);
        chk("ooo_empty_valid", bus.commit_valid_out, 0);

        // mispredict flush; alloc attempt on the flush edge is dropped
        do_reset();
        alloc(0, 0, 1); alloc(3, 1, 0); alloc(7, 1, 0);
        cdb(0, 85, 1);
        chk("mp_commit_valid", bus.commit_valid_out, 1);
        chk("mp_commit_idx", bus.commit_idx_out, 0);
        chk("mp_commit_we", bus.commit_we_out, 0);
        chk("mp_flush_pre", bus.flush_out, 0);
        alloc(9, 1, 0);
        #1;
        chk("mp_flush", bus.flush_out, 1);
        chk("mp_addr0", bus.flush_addrs_out[0], 0);
        chk("mp_addr1", bus.flush_addrs_out[1], 3);
        chk("mp_addr2", bus.flush_addrs_out[2], 7);
        chk("mp_addr3", bus.flush_addrs_out[3], 0);
        chk("mp_count", bus.count_out, 0);
        chk("mp_alloc_idx", bus.alloc_idx_out, 0);
        chk("mp_commit_after", bus.commit_valid_out, 0);
        tick();
        chk("mp_flush_drop", bus.flush_out, 0);

        // rd=0 destination never writes back
        alloc(0, 1, 0);
        cdb(0, 9, 0);
        chk("rd0_commit_valid", bus.commit_valid_out, 1);
        chk("rd0_commit_we", bus.commit_we_out, 0);
        chk("rd0_commit_data", bus.commit_data_out, 9);
        tick();

        // async reset with 4 busy entries and a mispredict commit pending
        build_mispredict();
        chk("ar_pre_count", bus.count_out, 4);
        chk("ar_pre_commit", bus.commit_valid_out, 1);
        #2;
        rst_in = 1;
        #1;
        chk("ar_count", bus.count_out, 0);
        chk("ar_commit_valid", bus.commit_valid_out, 0);
        chk("ar_ready", bus.ready_out, 1);
        chk("ar_alloc_idx", bus.alloc_idx_out, 0);
        chk("ar_commit_rd", bus.commit_rd_out, 0);
        chk("ar_q1_ready", bus.q1_ready_out, 0);
        tick();
        rst_in = 0;

        // async reset while flush is high
        build_mispredict();
        tick();
        chk("ar2_flush_pre", bus.flush_out, 1);
        chk("ar2_addr1_pre", bus.flush_addrs_out[1], 4);
        rst_in = 1;
        #1;
        chk("ar2_flush", bus.flush_out, 0);
        chk("ar2_addr1", bus.flush_addrs_out[1], 0);
        chk("ar2_addr3", bus.flush_addrs_out[3], 0);
        tick();
        rst_in = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
